// File: rtl/borrow_look_a_head_subtractor_pkg.sv
// Shared constants, pipeline stage record and lookahead helpers for the
// pipelined borrow-lookahead subtractor.
package borrow_la_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NUM_STAGES = WIDTH / SLICE_W;

    // One in-flight operation. Operands travel whole so later stages can
    // pick their slice; diff fills in from the low end as stages resolve.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b_n;
        logic [WIDTH-1:0] diff;
        logic             carry;
        logic             sign_a;
    } stage_t;

    // Carries into bits 0..3 of a 4-bit group, flat two-level lookahead.
    function automatic logic [3:0] cla4_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Group generate/propagate as {G, P}.
    function automatic logic [1:0] cla4_group(
        input logic [3:0] g,
        input logic [3:0] p
    );
        logic grp_g;
        logic grp_p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        return {grp_g, grp_p};
    endfunction

    // Fold one resolved slice into a stage record.
    function automatic stage_t merge_slice(
        input stage_t             s,
        input logic [SLICE_W-1:0] sum,
        input logic               cout,
        input int unsigned        k
    );
        stage_t r;
        r = s;
        r.diff[k*SLICE_W +: SLICE_W] = sum;
        r.carry = cout;
        return r;
    endfunction

endpackage

// File: rtl/borrow_look_a_head_subtractor_cla_slice8.sv
// Combinational 8-bit carry-lookahead slice: two 4-bit groups joined by a
// group-level lookahead, no internal ripple.
module cla_slice8
    import borrow_la_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [1:0] grp_lo;
    logic [1:0] grp_hi;
    logic       c4;
    logic [3:0] c_lo;
    logic [3:0] c_hi;

    assign g      = a & b;
    assign p      = a ^ b;
    assign grp_lo = cla4_group(g[3:0], p[3:0]);
    assign grp_hi = cla4_group(g[7:4], p[7:4]);

    // Both group carries are derived from cin directly, not from each other.
    assign c4   = grp_lo[1] | (grp_lo[0] & cin);
    assign cout = grp_hi[1] | (grp_hi[0] & grp_lo[1]) | (grp_hi[0] & grp_lo[0] & cin);

    assign c_lo = cla4_carries(g[3:0], p[3:0], cin);
    assign c_hi = cla4_carries(g[7:4], p[7:4], c4);
    assign sum  = p ^ {c_hi, c_lo};

endmodule

// File: rtl/borrow_look_a_head_subtractor.sv
// Pipelined subtractor Diff = A - B - Bin computed as A + ~B + ~Bin, one
// 8-bit lookahead slice per stage, with a global stall on output backpressure.
module borrow_look_a_head_subtractor #(
    parameter int unsigned WIDTH   = borrow_la_pkg::WIDTH,
    parameter int unsigned SLICE_W = borrow_la_pkg::SLICE_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
    input  logic             B_In_Bit,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Diff,
    output logic             B_Out,
    output logic             Overflow,
    output logic             Out_Valid,
    input  logic             Out_Ready
);

    import borrow_la_pkg::stage_t;
    import borrow_la_pkg::merge_slice;

    localparam int unsigned STAGES = WIDTH / SLICE_W;
    localparam int unsigned LAST   = STAGES - 1;

    stage_t                in_stage;
    stage_t [STAGES-1:0]   src_w;
    stage_t [STAGES-1:0]   res_w;
    stage_t                stage_q [STAGES-1];

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             advance;

    assign advance  = ~out_valid_q | Out_Ready;
    assign In_Ready = advance & ~Rst;

    always_comb begin
        in_stage        = '0;
        in_stage.valid  = In_Valid;
        in_stage.a      = A_In;
        in_stage.b_n    = ~B_In;
        in_stage.carry  = ~B_In_Bit;
        in_stage.sign_a = A_In[WIDTH-1];
    end

    assign src_w[0] = in_stage;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE_W-1:0] sum;
        logic               cout;

        if (k > 0) begin : g_link
            assign src_w[k] = stage_q[k-1];
        end

        cla_slice8 u_slice (
            .a   (src_w[k].a[k*SLICE_W +: SLICE_W]),
            .b   (src_w[k].b_n[k*SLICE_W +: SLICE_W]),
            .cin (src_w[k].carry),
            .sum (sum),
            .cout(cout)
        );

        assign res_w[k] = merge_slice(src_w[k], sum, cout, k);
    end

    // The final slice lands directly in the output registers, which only
    // reload on a valid result so the outputs hold across bubbles.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < LAST; i++) begin
                stage_q[i] <= '0;
            end
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned i = 0; i < LAST; i++) begin
                stage_q[i] <= res_w[i];
            end
            out_valid_q <= res_w[LAST].valid;
            if (res_w[LAST].valid) begin
                diff_q <= res_w[LAST].diff;
                bout_q <= ~res_w[LAST].carry;
                ovf_q  <= (res_w[LAST].sign_a == res_w[LAST].b_n[WIDTH-1])
                        & (res_w[LAST].diff[WIDTH-1] != res_w[LAST].sign_a);
            end
        end
    end

    assign Diff      = diff_q;
    assign B_Out     = bout_q;
    assign Overflow  = ovf_q;
    assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_borrow_look_a_head_subtractor.sv
// Scoreboard bench for the pipelined subtractor: directed corner vectors,
// backpressure, mid-stream reset and randomized traffic against a model.
module tb_borrow_look_a_head_subtractor;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] A_In;
    logic [31:0] B_In;
    logic        B_In_Bit;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Diff;
    logic        B_Out;
    logic        Overflow;
    logic        Out_Valid;
    logic        Out_Ready;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic rand_ready = 1'b0;

    borrow_look_a_head_subtractor #(
        .WIDTH  (32),
        .SLICE_W(8)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .A_In     (A_In),
        .B_In     (B_In),
        .B_In_Bit (B_In_Bit),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Diff     (Diff),
        .B_Out    (B_Out),
        .Overflow (Overflow),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready)
    );

    always #5 Clk = ~Clk;

    // Reference: plain 33-bit unsigned subtraction; overflow from sign rule.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] full;
        exp_t        r;
        full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        r.d  = full[31:0];
        r.bo = full[32];
        r.ov = (a[31] != b[31]) && (r.d[31] != a[31]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every consumed result; any output with nothing pending is stale.
    always @(negedge Clk) begin
        if (!Rst && Out_Valid) begin
            if (sb.size() == 0) begin
                check("stale_result", 64'(Out_Valid), 64'd0);
            end else if (Out_Ready) begin
                exp_t e;
                e = sb.pop_front();
                check("result", {30'd0, Diff, B_Out, Overflow}, {30'd0, e.d, e.bo, e.ov});
            end
        end
    end

    always @(posedge Clk) begin
        #1;
        if (rand_ready) Out_Ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin);
        bit acc;
        acc      = 1'b0;
        A_In     = a;
        B_In     = b;
        B_In_Bit = bin;
        In_Valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge Clk);
            if (In_Ready) begin
                sb.push_back(model(a, b, bin));
                acc = 1'b1;
            end
            @(posedge Clk);
            #1;
        end
        In_Valid = 1'b0;
        if (!acc) check("issue_timeout", 64'(In_Ready), 64'd1);
    endtask

    task automatic measure_latency(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (Out_Valid) begin
                n = i;
                break;
            end
        end
        check(name, 64'(n), 64'd4);
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        Out_Ready = 1'b1;
        for (int n = 0; n < 100 && sb.size() != 0; n++) begin
            @(posedge Clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] va [6] = '{32'd5, 32'd0, 32'h00000100, 32'hFFFFFFFF, 32'h80000000, 32'hF0F0F0F0};
    logic [31:0] vb [6] = '{32'd3, 32'd1, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'hAF0F0F0F};
    logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int          idx;
        int          accepted;
        bit          have_hold;
        logic [34:0] held;
        logic [31:0] ra;
        logic [31:0] rb;

        Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
        A_In = '0; B_In = '0; B_In_Bit = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_out_valid", 64'(Out_Valid), 64'd0);
        check("rst_diff",      64'(Diff),      64'd0);
        check("rst_b_out",     64'(B_Out),     64'd0);
        check("rst_overflow",  64'(Overflow),  64'd0);
        check("rst_in_ready",  64'(In_Ready),  64'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_in_ready", 64'(In_Ready), 64'd1);
        @(posedge Clk); #1;

        // Directed vectors; the first one also times the pipeline.
        issue(va[0], vb[0], vc[0]);
        measure_latency("latency");
        for (int i = 1; i < 6; i++) issue(va[i], vb[i], vc[i]);
        drain();

        // Backpressure: six ops offered while the consumer stalls for 8 cycles.
        Out_Ready = 1'b0;
        idx = 0; accepted = 0; have_hold = 1'b0; held = '0;
        for (int c = 0; c < 8; c++) begin
            In_Valid = (idx < 6);
            A_In = 32'h1000_0000 * (idx + 1) + 32'd77;
            B_In = 32'h0300_0000 * (idx + 2) + 32'd9;
            B_In_Bit = idx[0];
            @(negedge Clk);
            check("bp_in_ready", 64'(In_Ready), 64'(accepted < 4));
            if (In_Valid && In_Ready) begin
                sb.push_back(model(A_In, B_In, B_In_Bit));
                idx++; accepted++;
            end
            if (Out_Valid) begin
                if (have_hold) check("bp_hold", 64'({Diff, B_Out, Overflow, Out_Valid}), 64'(held));
                held = {Diff, B_Out, Overflow, Out_Valid};
                have_hold = 1'b1;
            end
            @(posedge Clk); #1;
        end
        check("bp_in_flight", 64'(accepted), 64'd4);
        Out_Ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            In_Valid = (idx < 6);
            A_In = 32'h1000_0000 * (idx + 1) + 32'd77;
            B_In = 32'h0300_0000 * (idx + 2) + 32'd9;
            B_In_Bit = idx[0];
            @(negedge Clk);
            check("bp_consecutive", 64'(Out_Valid), 64'd1);
            if (In_Valid && In_Ready) begin
                sb.push_back(model(A_In, B_In, B_In_Bit));
                idx++;
            end
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        check("bp_all_accepted", 64'(idx), 64'd6);
        drain();

        // Reset with three operations in flight.
        issue(32'h0000_0010, 32'h0000_0001, 1'b0);
        issue(32'h1234_5678, 32'h0000_1111, 1'b1);
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        Rst = 1'b1;
        sb.delete();
        @(negedge Clk);
        check("mid_rst_in_ready", 64'(In_Ready), 64'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("mid_rst_out_valid", 64'(Out_Valid), 64'd0);
        check("mid_rst_outputs",   64'({Diff, B_Out, Overflow}), 64'd0);
        check("mid_rst_in_ready1", 64'(In_Ready), 64'd1);
        repeat (6) @(posedge Clk);
        #1;
        issue(32'h0000_0100, 32'h0000_0001, 1'b0);
        measure_latency("latency_after_rst");
        drain();

        // Randomized traffic with random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 32'h0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge Clk);
                #1;
            end
            issue(ra, rb, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
